// File: rtl/dado_ctrl.sv
// Electronic die roll controller: debounced button drives fast cycling,
// a decelerating spin-down and a settled face with load strobe.
module dado_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int ROLL_DIV     = 2,
  parameter int SLOW_INC     = 2,
  parameter int SLOW_STEPS   = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       boton_i,
  output logic [2:0] cara_o,
  output logic       enable_o,
  output logic       rolling_o,
  output logic       done_o
);

  localparam int TMAX = (SLOW_INC * SLOW_STEPS > ROLL_DIV)
                      ? SLOW_INC * SLOW_STEPS : ROLL_DIV;
  localparam int TW = $clog2(TMAX + 1);
  localparam int KW = $clog2(SLOW_STEPS + 2);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SLOW = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          db_q, db_dly_q;
  logic [DW-1:0] db_cnt_q;
  logic [TW-1:0] timer_q, timer_d, slow_lim;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    cara_q;
  logic          enable_q, done_q;
  logic          step, done_d, rise, fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= boton_i;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      if (sync2_q == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
        db_q     <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end
    end
  end

  assign rise     = db_q & ~db_dly_q;
  assign fall     = ~db_q & db_dly_q;
  assign slow_lim = TW'(SLOW_INC * int'(k_q) - 1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    k_d     = k_q;
    step    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        // a press landing on the done cycle belongs to the old roll
        if (rise && !done_q) state_d = ROLL;
      end
      ROLL: begin
        if (fall) begin
          state_d = SLOW;
          timer_d = '0;
          k_d     = KW'(1);
        end else if (timer_q == TW'(ROLL_DIV - 1)) begin
          step    = 1'b1;
          timer_d = '0;
        end
      end
      SLOW: begin
        // last step's strobe stays inside SLOW; leave on the next cycle
        if (k_q > KW'(SLOW_STEPS)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          timer_d = '0;
        end else if (timer_q == slow_lim) begin
          step    = 1'b1;
          k_d     = k_q + KW'(1);
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      k_q      <= '0;
      cara_q   <= 3'd1;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      k_q      <= k_d;
      enable_q <= step;
      done_q   <= done_d;
      if (step) cara_q <= (cara_q == 3'd6) ? 3'd1 : cara_q + 3'd1;
    end
  end

  assign cara_o    = cara_q;
  assign enable_o  = enable_q;
  assign done_o    = done_q;
  assign rolling_o = (state_q != IDLE);

endmodule

// File: tb/tb_dado_ctrl.sv
// Directed bench for dado_ctrl: debounce, roll timing, wrap,
// ignored presses, async reset and strobe accounting.
module tb_dado_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       boton;
  logic [2:0] cara;
  logic       enable, rolling, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int chg_cnt = 0;
  logic [2:0] prev_cara = 3'd1;
  int exp_roll[10] = '{2, 3, 4, 5, 6, 1, 2, 3, 4, 5};
  int exp_slow[6] = '{6, 1, 2, 3, 4, 5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dado_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .boton_i  (boton),
    .cara_o   (cara),
    .enable_o (enable),
    .rolling_o(rolling),
    .done_o   (done)
  );

  always @(negedge clk) begin
    if (rst) begin
      prev_cara = cara;
    end else begin
      n_cmp++;
      if (cara == 3'd0 || cara == 3'd7) begin
        n_bad++;
        $display("FAIL range: cara=%0d required 1..6", cara);
      end
      n_cmp++;
      if (enable && !rolling) begin
        n_bad++;
        $display("FAIL en_idle: enable=1 rolling=%0d required 1",
                 rolling);
      end
      if (cara !== prev_cara) chg_cnt++;
      if (enable) en_cnt++;
      prev_cara = cara;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int next_face(int f, int n);
    return ((f - 1 + n) % 6) + 1;
  endfunction

  task automatic do_roll(input int h, output int pulses,
                         output logic [2:0] first,
                         output logic [2:0] last, output int dones);
    int post;
    pulses = 0;
    dones  = 0;
    first  = 3'd0;
    post   = -1;
    boton  = 1'b1;
    for (int i = 0; i < h; i++) begin
      tick();
      if (enable) begin
        if (pulses == 0) first = cara;
        pulses++;
      end
    end
    boton = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (enable) begin
        if (pulses == 0) first = cara;
        pulses++;
      end
      if (done) dones++;
      if (dones > 0) post++;
      if (post == 3) break;
    end
    last = cara;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    boton = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (cara !== 3'd1) begin
      n_bad++; $display("FAIL rst_cara: got %0d required 1", cara);
    end
    n_cmp++;
    if ({enable, rolling, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_flags: got %b required 000",
               {enable, rolling, done});
    end
    rst = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (rolling !== 1'b0 || cara !== 3'd1) begin
      n_bad++;
      $display("FAIL rst_idle: rolling=%0d cara=%0d required 0/1",
               rolling, cara);
    end
  endtask

  task automatic test_bounce();
    int roll_seen = 0;
    for (int p = 0; p < 5; p++) begin
      boton = 1'b1;
      repeat (3) begin tick(); if (rolling) roll_seen++; end
      boton = 1'b0;
      repeat (3) begin tick(); if (rolling) roll_seen++; end
    end
    repeat (10) begin tick(); if (rolling) roll_seen++; end
    n_cmp++;
    if (roll_seen !== 0) begin
      n_bad++;
      $display("FAIL bounce_roll: rolling cycles=%0d required 0",
               roll_seen);
    end
    n_cmp++;
    if (cara !== 3'd1) begin
      n_bad++; $display("FAIL bounce_cara: got %0d required 1", cara);
    end
  endtask

  task automatic test_full_roll();
    int tc[$];
    int vals[$];
    int done_cyc = -1;
    int dones = 0;
    boton = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (enable) begin tc.push_back(cyc); vals.push_back(int'(cara)); end
    end
    boton = 1'b0;
    for (int i = 0; i < 200 && done_cyc < 0; i++) begin
      tick();
      if (enable) begin tc.push_back(cyc); vals.push_back(int'(cara)); end
      if (done) begin done_cyc = cyc; dones++; end
    end
    repeat (3) begin tick(); if (done) dones++; end
    n_cmp++;
    if (vals.size() != 16) begin
      n_bad++;
      $display("FAIL full_pulses: got %0d required 16", vals.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (vals[i] != exp_roll[i]) begin
          n_bad++;
          $display("FAIL roll_face%0d: got %0d required %0d",
                   i, vals[i], exp_roll[i]);
        end
        if (i > 0) begin
          n_cmp++;
          if (tc[i] - tc[i-1] != 2) begin
            n_bad++;
            $display("FAIL roll_gap%0d: got %0d required 2",
                     i, tc[i] - tc[i-1]);
          end
        end
      end
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (vals[10+i] != exp_slow[i]) begin
          n_bad++;
          $display("FAIL slow_face%0d: got %0d required %0d",
                   i, vals[10+i], exp_slow[i]);
        end
        n_cmp++;
        if (tc[10+i] - tc[9+i] != ((i == 0) ? 3 : 2 * (i + 1))) begin
          n_bad++;
          $display("FAIL slow_gap%0d: got %0d required %0d", i,
                   tc[10+i] - tc[9+i], (i == 0) ? 3 : 2 * (i + 1));
        end
      end
      n_cmp++;
      if (done_cyc - tc[15] != 1) begin
        n_bad++;
        $display("FAIL done_lat: got %0d required 1",
                 done_cyc - tc[15]);
      end
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++; $display("FAIL full_done: got %0d required 1", dones);
    end
    n_cmp++;
    if (cara !== 3'd5 || rolling !== 1'b0) begin
      n_bad++;
      $display("FAIL full_end: cara=%0d rolling=%0d required 5/0",
               cara, rolling);
    end
  endtask

  task automatic test_wrap();
    int p, d;
    logic [2:0] f, l;
    do_roll(4, p, f, l, d);
    n_cmp++;
    if (p != 7 || l !== 3'd6 || d != 1) begin
      n_bad++;
      $display("FAIL wrap_prep: pulses=%0d cara=%0d done=%0d required 7/6/1",
               p, l, d);
    end
    do_roll(4, p, f, l, d);
    n_cmp++;
    if (f !== 3'd1) begin
      n_bad++; $display("FAIL wrap_step: got %0d required 1", f);
    end
    n_cmp++;
    if (l !== 3'd1 || d != 1) begin
      n_bad++;
      $display("FAIL wrap_end: cara=%0d done=%0d required 1/1", l, d);
    end
  endtask

  task automatic test_press_during_slow();
    int p = 0;
    int d = 0;
    int late = 0;
    boton = 1'b1;
    repeat (6) begin tick(); if (enable) p++; end
    boton = 1'b0;
    repeat (20) begin tick(); if (enable) p++; end
    boton = 1'b1;
    repeat (8) begin tick(); if (enable) p++; end
    boton = 1'b0;
    for (int i = 0; i < 200 && d == 0; i++) begin
      tick();
      if (enable) p++;
      if (done) d++;
    end
    repeat (40) begin tick(); if (rolling) late++; if (done) d++; end
    n_cmp++;
    if (p != 8 || cara !== 3'd3) begin
      n_bad++;
      $display("FAIL slow_press: pulses=%0d cara=%0d required 8/3",
               p, cara);
    end
    n_cmp++;
    if (d != 1 || late != 0) begin
      n_bad++;
      $display("FAIL slow_press_end: done=%0d rolling=%0d required 1/0",
               d, late);
    end
    p = 0; d = 0; late = 0;
    boton = 1'b1;
    repeat (6) begin tick(); if (enable) p++; end
    boton = 1'b0;
    repeat (44) begin tick(); if (enable) p++; end
    boton = 1'b1;
    for (int i = 0; i < 200 && d == 0; i++) begin
      tick();
      if (enable) p++;
      if (done) d++;
    end
    repeat (40) begin tick(); if (rolling) late++; if (enable) p++; end
    boton = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (p != 8 || cara !== 3'd5 || d != 1) begin
      n_bad++;
      $display("FAIL held_done: pulses=%0d cara=%0d done=%0d required 8/5/1",
               p, cara, d);
    end
    n_cmp++;
    if (late != 0) begin
      n_bad++;
      $display("FAIL held_roll: rolling cycles=%0d required 0", late);
    end
  endtask

  task automatic test_reset_mid_slow();
    int act = 0;
    boton = 1'b1;
    repeat (6) tick();
    boton = 1'b0;
    repeat (15) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cara !== 3'd1 || {enable, rolling, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_rst: cara=%0d flags=%b required 1/000",
               cara, {enable, rolling, done});
    end
    tick();
    rst = 1'b0;
    repeat (60) begin
      tick();
      if (enable || rolling || done) act++;
    end
    n_cmp++;
    if (act != 0 || cara !== 3'd1) begin
      n_bad++;
      $display("FAIL post_rst: active=%0d cara=%0d required 0/1",
               act, cara);
    end
  endtask

  task automatic test_random();
    int en0, ch0, h, p, d, start;
    logic [2:0] f, l;
    en0 = en_cnt;
    ch0 = chg_cnt;
    for (int r = 0; r < 80; r++) begin
      h = $urandom_range(4, 30);
      start = int'(cara);
      do_roll(h, p, f, l, d);
      n_cmp++;
      if (int'(l) != next_face(start, (h - 1) / 2 + 6) || d != 1) begin
        n_bad++;
        $display("FAIL rand%0d: cara=%0d done=%0d required %0d/1", r,
                 l, d, next_face(start, (h - 1) / 2 + 6));
      end
      repeat ($urandom_range(1, 10)) tick();
    end
    n_cmp++;
    if (en_cnt - en0 != chg_cnt - ch0) begin
      n_bad++;
      $display("FAIL en_count: enables=%0d required %0d",
               en_cnt - en0, chg_cnt - ch0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    boton = 1'b0;
    test_reset();
    test_bounce();
    test_full_roll();
    test_wrap();
    test_press_during_slow();
    test_reset_mid_slow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
